// File: rtl/cfg_frame_loader.sv
// cfg_frame_loader: CRC-8 checked serial frame loader with atomic commit of the configuration word.
// Define CFG_READBACK_EN to add serial readback of cfg_data on sdo.
module cfg_frame_loader #(
    parameter int WIDTH = 79,
    parameter logic [WIDTH-1:0] CFG_RESET = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic             sdi,
    output logic [WIDTH-1:0] cfg_data,
    output logic             cfg_update,
    output logic             busy,
    output logic             crc_err,
    output logic             len_err,
    input  logic             rb_en,
    output logic             sdo
);
    localparam int FRAME = WIDTH + 8;
    localparam int CW = $clog2(FRAME + 1);
    localparam logic [CW-1:0] FRAME_C = CW'(FRAME);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t state, state_nx;
    logic [FRAME-1:0] shadow;
    logic [7:0] crc, crc_in, crc_nx;
    logic [CW-1:0] count;
    logic ovf, fb, frame_end, len_bad, crc_bad, commit;

    always_comb begin
        state_nx = load_en ? SHIFT : IDLE;
        crc_in = (state == IDLE) ? 8'h00 : crc;
        fb = crc_in[7] ^ sdi;
        crc_nx = {crc_in[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        frame_end = (state == SHIFT) && !load_en;
        len_bad = frame_end && (count != FRAME_C || ovf);
        crc_bad = frame_end && !len_bad && crc != 8'h00;
        commit = frame_end && !len_bad && crc == 8'h00;
    end

    assign busy = (state == SHIFT);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow <= '0;
            crc <= 8'h00;
            count <= '0;
            ovf <= 1'b0;
            cfg_data <= CFG_RESET;
            cfg_update <= 1'b0;
            crc_err <= 1'b0;
            len_err <= 1'b0;
        end else begin
            cfg_update <= commit;
            if (load_en) begin
                shadow <= {sdi, shadow[FRAME-1:1]};
                crc <= crc_nx;
            end
            // First bit of a frame restarts the length tracking and clears stale errors
            if (load_en && state == IDLE) begin
                count <= CW'(1);
                ovf <= 1'b0;
                crc_err <= 1'b0;
                len_err <= 1'b0;
            end else if (load_en) begin
                if (count == FRAME_C) ovf <= 1'b1;
                else count <= count + 1'b1;
            end
            if (commit) cfg_data <= shadow[WIDTH-1:0];
            if (len_bad) len_err <= 1'b1;
            if (crc_bad) crc_err <= 1'b1;
        end
    end

`ifdef CFG_READBACK_EN
    localparam int RW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    logic [RW-1:0] rb_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rb_idx <= '0;
            sdo <= 1'b0;
        end else begin
            sdo <= (state == IDLE && rb_en && !load_en) ? cfg_data[rb_idx] : 1'b0;
            if (state == SHIFT || load_en || !rb_en) rb_idx <= '0;
            else rb_idx <= (rb_idx == RW'(WIDTH - 1)) ? '0 : rb_idx + 1'b1;
        end
    end
`else
    logic rb_unused;
    assign rb_unused = rb_en;
    assign sdo = 1'b0;
`endif
endmodule

// File: tb/tb_cfg_frame_loader.sv
// tb_cfg_frame_loader: scoreboard bench for cfg_frame_loader at WIDTH=8 and WIDTH=79.
module tb_cfg_frame_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic le8 = 1'b0, sd8 = 1'b0, rb8 = 1'b0;
    logic le79 = 1'b0, sd79 = 1'b0, rb79 = 1'b0;
    logic [7:0] cfg8;
    logic [78:0] cfg79;
    logic upd8, busy8, ce8, lee8, sdo8;
    logic upd79, busy79, ce79, lee79, sdo79;

    typedef struct {
        logic [127:0] cfg;
        logic upd;
        logic ce;
        logic le;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    logic [127:0] m8 = '0;
    logic [127:0] m79 = '0;

    always #5 clk = ~clk;

    cfg_frame_loader #(.WIDTH(8), .CFG_RESET(8'h00)) u8 (
        .clk(clk), .rst_n(rst_n), .load_en(le8), .sdi(sd8), .cfg_data(cfg8),
        .cfg_update(upd8), .busy(busy8), .crc_err(ce8), .len_err(lee8),
        .rb_en(rb8), .sdo(sdo8)
    );

    cfg_frame_loader u79 (
        .clk(clk), .rst_n(rst_n), .load_en(le79), .sdi(sd79), .cfg_data(cfg79),
        .cfg_update(upd79), .busy(busy79), .crc_err(ce79), .len_err(lee79),
        .rb_en(rb79), .sdo(sdo79)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic le, input logic d);
        if (sel) begin
            le79 = le;
            sd79 = d;
        end else begin
            le8 = le;
            sd8 = d;
        end
    endtask

    function automatic logic [7:0] crc_of(input logic [127:0] b, input int n);
        logic [7:0] c = 8'h00;
        for (int i = 0; i < n; i++) c = {c[6:0], 1'b0} ^ ((c[7] ^ b[i]) ? 8'h07 : 8'h00);
        return c;
    endfunction

    function automatic logic [127:0] make_frame(input int w, input logic [127:0] d);
        logic [127:0] f = '0;
        logic [7:0] c;
        for (int k = 0; k < w; k++) f[k] = d[k];
        c = crc_of(f, w);
        for (int j = 0; j < 8; j++) f[w + j] = c[7 - j];
        return f;
    endfunction

    function automatic logic [127:0] gcfg(input bit sel);
        return sel ? 128'(cfg79) : 128'(cfg8);
    endfunction

    task automatic send(input bit sel, input int n, input logic [127:0] bits);
        exp_t e;
        int w;
        logic [127:0] m;
        w = sel ? 79 : 8;
        m = sel ? m79 : m8;
        e.le = (n != w + 8);
        e.ce = !e.le && crc_of(bits, n) != 8'h00;
        e.upd = !(e.le || e.ce);
        e.cfg = m;
        if (e.upd) begin
            e.cfg = '0;
            for (int k = 0; k < w; k++) e.cfg[k] = bits[k];
        end
        sb.push_back(e);
        for (int i = 0; i < n; i++) begin
            drive(sel, 1'b1, bits[i]);
            step;
            if (i == 0) begin
                check("busy_start", 128'(sel ? busy79 : busy8), 128'd1);
                check("flags_clr", 128'(sel ? {ce79, lee79} : {ce8, lee8}), 128'd0);
            end
            if (i == n / 2) check("cfg_hold", gcfg(sel), m);
        end
        drive(sel, 1'b0, 1'b0);
        step;
        e = sb.pop_front();
        check("cfg", gcfg(sel), e.cfg);
        check("upd", 128'(sel ? upd79 : upd8), 128'(e.upd));
        check("crc_err", 128'(sel ? ce79 : ce8), 128'(e.ce));
        check("len_err", 128'(sel ? lee79 : lee8), 128'(e.le));
        check("busy_end", 128'(sel ? busy79 : busy8), 128'd0);
        step;
        check("upd_pulse", 128'(sel ? upd79 : upd8), 128'd0);
        if (sel) m79 = e.cfg;
        else m8 = e.cfg;
    endtask

    initial begin
        logic [127:0] f;
        le8 = 1'b1;
        le79 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sd8 = i[0];
            sd79 = ~i[0];
            step;
        end
        check("rst_cfg8", 128'(cfg8), 128'd0);
        check("rst_flags8", 128'({busy8, upd8, ce8, lee8, sdo8}), 128'd0);
        check("rst_cfg79", 128'(cfg79), 128'd0);
        check("rst_flags79", 128'({busy79, upd79, ce79, lee79, sdo79}), 128'd0);
        rst_n = 1'b1;
        le8 = 1'b0;
        le79 = 1'b0;
        step;

        send(1'b0, 16, 128'h9101);
        send(1'b0, 16, 128'h1101);
        send(1'b0, 15, 128'h9101);
        send(1'b0, 17, 128'h19101);
        send(1'b0, 16, make_frame(8, 128'h3C));
        for (int r = 0; r < 3; r++) send(1'b0, 16, make_frame(8, 128'($urandom)));
        send(1'b0, 16, make_frame(8, 128'hA5));

        rb8 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step;
`ifdef CFG_READBACK_EN
            check("sdo", 128'(sdo8), 128'(m8[i % 8]));
`else
            check("sdo", 128'(sdo8), 128'd0);
`endif
        end
        rb8 = 1'b0;
        step;
        check("sdo_off", 128'(sdo8), 128'd0);

        send(1'b1, 87, make_frame(79, {$urandom, $urandom, $urandom}));
        f = make_frame(79, {$urandom, $urandom, $urandom});
        f[3] = ~f[3];
        send(1'b1, 87, f);
        send(1'b1, 86, make_frame(79, 128'h1234));

        f = make_frame(79, {$urandom, $urandom, $urandom});
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 1'b1, f[i]);
            step;
        end
        rst_n = 1'b0;
        step;
        step;
        drive(1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        step;
        m79 = '0;
        m8 = '0;
        check("midrst_cfg", 128'(cfg79), 128'd0);
        check("midrst_flags", 128'({busy79, upd79, ce79, lee79}), 128'd0);
        send(1'b1, 87, make_frame(79, {10{8'h5A}}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cfg_frame_loader.md
Name: cfg_frame_loader

Overview:
- Serial configuration front end that replaces the bare enable/data shift register feeding the DLL, ADC and delay-line configuration bus.
- Each frame is a fixed-length, CRC-8-protected serial frame captured on two pad inputs into a shadow register.
- The frame is committed atomically to the active configuration word only when length and CRC both check.
- The consumers never see a partially shifted or corrupted configuration.

Parameters:
- WIDTH, 79, number of configuration bits delivered on cfg_data.
- CFG_RESET, {WIDTH{1'b0}}, value loaded into cfg_data by reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- load_en  input  1  frame strobe; high while frame bits are presented (pad ui_in[0]).
- sdi  input  1  serial data, sampled on every clk edge where load_en=1 (pad ui_in[1]).
- cfg_data  output  WIDTH  active configuration word.
- cfg_update  output  1  one-cycle pulse on the cycle after a successful commit.
- busy  output  1  high while in SHIFT.
- crc_err  output  1  sticky; last frame failed CRC.
- len_err  output  1  sticky; last frame had bit count not equal to WIDTH+8.
- rb_en  input  1  readback enable (used only with optional feature).
- sdo  output  1  readback serial out.

Behaviour:
- Frame format: WIDTH data bits, data bit 0 first, then 8-bit CRC trailer, CRC MSB first. Total FRAME = WIDTH+8 bits.
- CRC: CRC-8, polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR.
  - Computed over all received bits in arrival order, trailer included.
  - Remainder 0x00 = pass.
- Shadow register: FRAME bits. Each accepted bit enters at the MSB and shifts toward the LSB. After a full frame, data bit k sits at shadow[k].
- Bit counter: width clog2(FRAME+1). Saturates at FRAME; an overflow flag sets if a bit arrives while the count equals FRAME.
- State machine, two states IDLE and SHIFT:
  - IDLE, load_en=1: go to SHIFT. Capture sdi as bit 1, crc from first bit, count=1. Clear crc_err and len_err. busy=1 from next cycle.
  - SHIFT, load_en=1: shift sdi in, update crc, increment count (or set overflow).
  - SHIFT, load_en=0 (frame end): return to IDLE. At this edge:
    - count==FRAME, no overflow, crc==0: cfg_data <= shadow[WIDTH-1:0] and cfg_update=1 for exactly the following cycle.
    - Else if count!=FRAME or overflow: len_err<=1 and cfg_data is unchanged.
    - Else (length OK, CRC nonzero): crc_err<=1 and cfg_data is unchanged.
    - len_err takes precedence; crc_err is not set alongside it.
- Back-to-back frames: minimum one cycle of load_en=0 between frames. A frame can start on the cycle immediately after the end cycle.
- Reset (any time, including mid-frame):
  - state=IDLE; shadow, crc and count cleared; partial frame discarded.
  - cfg_data=CFG_RESET; cfg_update=0, busy=0, crc_err=0, len_err=0, sdo=0.
- cfg_data changes only on a successful commit or on reset, never during SHIFT.
- Latency: commit visible on cfg_data one clk after the first cycle load_en is sampled low.

Optional Feature:
- Macro: CFG_READBACK_EN
- Defined:
  - In IDLE with rb_en=1, sdo presents cfg_data[rb_idx], registered; rb_idx advances by 1 per cycle and wraps from WIDTH-1 to 0.
  - rb_idx resets to 0 when rb_en=0, on commit, on reset, and when entering SHIFT.
  - sdo=0 in SHIFT.
- Not defined: sdo tied 0, rb_en ignored, no readback logic synthesized.

Test Plan:
- Reset values: hold rst_n=0 for 3 cycles with load_en=1 and sdi toggling -> cfg_data=CFG_RESET; busy, cfg_update, crc_err, len_err all 0.
- Good frame, WIDTH=8 override:
  - Stimulus: send data 0x01 (bits 1,0,0,0,0,0,0,0) then CRC 0x89 (1,0,0,0,1,0,0,1), then load_en=0.
  - Response: cfg_data=0x01 one cycle after load_en low; cfg_update high exactly 1 cycle; no error flags.
- Bad CRC, WIDTH=8: same frame with trailer 0x88 -> crc_err=1, len_err=0, cfg_data keeps previous 0x01, no cfg_update.
- Length errors:
  - Frame of 15 bits -> len_err=1, cfg_data unchanged.
  - Frame of 17 bits -> len_err=1, cfg_data unchanged.
  - Next valid frame -> both flags clear at frame start, then commit.
- Mid-frame reset, WIDTH=79: assert rst_n=0 after 40 bits, then send a full valid frame with data 0x5A5A... -> cfg_data=CFG_RESET after reset, then the new value after the good frame.
- Readback (CFG_READBACK_EN, WIDTH=8, cfg_data=0xA5): rb_en=1 for 10 cycles -> sdo sequence 1,0,1,0,0,1,0,1,1,0.
